aes_dec_key_sched_ctrl: RTL and testbench

Sequencing controller for the iterative AES-128 decryption key scheduler. It drives the scheduler's 2-bit mux select and round number so that the scheduler register is:
- loaded with the cipher key;
- expanded forward to the round-10 key;
- stepped backwards one round key per decryption round on request from the round datapath.

It sits directly upstream of the key scheduler and beside the decryption round datapath. It hands that datapath a valid/advance handshake and the index of the round key currently held.

---
 rtl/aes_dec_key_sched_ctrl_if.sv | 34 +++
 rtl/aes_dec_key_sched_ctrl.sv | 103 ++++++++++
 tb/tb_aes_dec_key_sched_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_key_sched_ctrl_if.sv
// Handshake and scheduler-control bundle between the AES-128 decryption key
// scheduler controller (slave) and the round datapath / scheduler side (master).
interface aes_dec_key_sched_ctrl_if;
    logic       key_valid;
    logic       key_ready;
    logic       round_advance;
    logic       round_key_valid;
    logic [3:0] key_index;
    logic       busy;
    logic [1:0] control_signal;
    logic [3:0] round_number;

    modport master (
        output key_valid,
        output round_advance,
        input  key_ready,
        input  round_key_valid,
        input  key_index,
        input  busy,
        input  control_signal,
        input  round_number
    );

    modport slave (
        input  key_valid,
        input  round_advance,
        output key_ready,
        output round_key_valid,
        output key_index,
        output busy,
        output control_signal,
        output round_number
    );
endinterface

// File: rtl/aes_dec_key_sched_ctrl.sv
// Sequencer for the iterative AES-128 decryption key scheduler: load the cipher
// key, expand forward to round key NR, then step back one key per request.
module aes_dec_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    aes_dec_key_sched_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        READY  = 2'd3
    } state_t;

    localparam logic [3:0] NR_U     = 4'(NR);
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_FWD  = 2'b10;
    localparam logic [1:0] SEL_REV  = 2'b11;

    state_t     state, state_nxt;
    logic [3:0] exp_cnt, exp_cnt_nxt;
    logic [3:0] key_index, key_index_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exp_cnt   <= 4'd0;
            key_index <= 4'd0;
        end else begin
            state     <= state_nxt;
            exp_cnt   <= exp_cnt_nxt;
            key_index <= key_index_nxt;
        end
    end

    // Select and round number are decoded combinationally so the scheduler sees
    // them before the same edge that moves the controller.
    always_comb begin
        state_nxt          = state;
        exp_cnt_nxt        = exp_cnt;
        key_index_nxt      = key_index;
        bus.control_signal = SEL_HOLD;
        bus.round_number   = 4'd0;
        bus.key_ready      = 1'b0;
        bus.round_key_valid = 1'b0;
        bus.busy           = 1'b0;

        case (state)
            IDLE: begin
                bus.key_ready = 1'b1;
                if (bus.key_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                bus.control_signal = SEL_LOAD;
                bus.busy           = 1'b1;
                state_nxt          = EXPAND;
                exp_cnt_nxt        = 4'd1;
            end
            EXPAND: begin
                bus.control_signal = SEL_FWD;
                bus.round_number   = exp_cnt;
                bus.busy           = 1'b1;
                if (exp_cnt == NR_U) begin
                    state_nxt     = READY;
                    key_index_nxt = NR_U;
                end else begin
                    exp_cnt_nxt = exp_cnt + 4'd1;
                end
            end
            READY: begin
                bus.key_ready       = 1'b1;
                bus.round_key_valid = 1'b1;
                if (bus.key_valid) begin
                    // A new key flushes the current schedule; any advance is dropped.
                    state_nxt = LOAD;
                end else if (bus.round_advance) begin
                    if (key_index != 4'd0) begin
                        bus.control_signal = SEL_REV;
                        bus.round_number   = key_index;
                        key_index_nxt      = key_index - 4'd1;
                    end else begin
                        // Register holds the cipher key again: re-expand in place.
                        bus.round_key_valid = 1'b0;
                        state_nxt           = EXPAND;
                        exp_cnt_nxt         = 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.key_index = key_index;

endmodule

// File: tb/tb_aes_dec_key_sched_ctrl.sv
// Bench for the key scheduler controller with a behavioural AES-128 key
// scheduler register driven by the controller's select and round number.
module tb_aes_dec_key_sched_ctrl;

    localparam int NR = 10;

    logic         clk;
    logic         rst_n;
    logic [127:0] load_key_in;
    logic [127:0] sched;

    aes_dec_key_sched_ctrl_if bus ();

    aes_dec_key_sched_ctrl #(.NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sbox [0:255];
    initial begin
        sbox = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
        };
    end

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox[r[31:24]], sbox[r[23:16]], sbox[r[15:8]], sbox[r[7:0]]};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1: c = 8'h01;  4'd2: c = 8'h02;  4'd3: c = 8'h04;  4'd4: c = 8'h08;
            4'd5: c = 8'h10;  4'd6: c = 8'h20;  4'd7: c = 8'h40;  4'd8: c = 8'h80;
            4'd9: c = 8'h1b;  4'd10: c = 8'h36; default: c = 8'h00;
        endcase
        return {c, 24'h0};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ rcon(r);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_rev(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ rcon(r);
        return {p0, p1, p2, p3};
    endfunction

    always_ff @(posedge clk) begin
        case (bus.control_signal)
            2'b01:   sched <= load_key_in;
            2'b10:   sched <= key_fwd(sched, bus.round_number);
            2'b11:   sched <= key_rev(sched, bus.round_number);
            default: sched <= sched;
        endcase
    end

    int checks_total = 0;
    int checks_passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [127:0] rk [0:10];

    typedef struct {
        logic         adv;
        logic [1:0]   cs;
        logic [3:0]   rn;
        logic [3:0]   idx_after;
        logic [127:0] key_after;
    } rev_vec_t;
    rev_vec_t rev_tbl [0:9];

    task automatic load_key(input logic [127:0] k, input logic adv, input logic junk,
                            input bit steps, input logic [3:0] prev_idx,
                            input logic [127:0] final_key);
        @(negedge clk);
        bus.key_valid     = 1'b1;
        bus.round_advance = adv;
        load_key_in       = k;
        #1;
        chk("accept_key_ready", 128'(bus.key_ready), 128'd1);
        chk("accept_cs_hold", 128'(bus.control_signal), 128'd0);
        @(negedge clk);
        bus.key_valid     = junk;
        bus.round_advance = junk;
        #1;
        chk("load_cs", 128'(bus.control_signal), 128'd1);
        chk("load_busy", 128'(bus.busy), 128'd1);
        chk("load_key_ready", 128'(bus.key_ready), 128'd0);
        chk("load_idx_kept", 128'(bus.key_index), 128'(prev_idx));
        for (int i = 1; i <= NR; i++) begin
            @(negedge clk);
            #1;
            chk("expand_cs", 128'(bus.control_signal), 128'd2);
            chk("expand_rn", 128'(bus.round_number), 128'(i));
            chk("expand_rkv", 128'(bus.round_key_valid), 128'd0);
            if (steps) chk("expand_reg", sched, rk[i-1]);
        end
        @(negedge clk);
        bus.key_valid     = 1'b0;
        bus.round_advance = 1'b0;
        #1;
        chk("ready_rkv_at_t12", 128'(bus.round_key_valid), 128'd1);
        chk("ready_idx", 128'(bus.key_index), 128'd10);
        chk("ready_busy", 128'(bus.busy), 128'd0);
        chk("ready_reg", sched, final_key);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowcnt;
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int j = 0; j < 10; j++)
            rev_tbl[j] = '{1'b1, 2'b11, 4'(10 - j), 4'(9 - j), rk[9 - j]};

        rst_n             = 1'b0;
        bus.key_valid     = 1'b0;
        bus.round_advance = 1'b0;
        load_key_in       = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cs", 128'(bus.control_signal), 128'd0);
        chk("rst_rn", 128'(bus.round_number), 128'd0);
        chk("rst_key_ready", 128'(bus.key_ready), 128'd1);
        chk("rst_rkv", 128'(bus.round_key_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_idx", 128'(bus.key_index), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load_key(rk[0], 1'b0, 1'b0, 1'b1, 4'd0, rk[10]);

        // Reverse walk, one advance per cycle
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            bus.round_advance = rev_tbl[j].adv;
            #1;
            if (j > 0) begin
                chk("rev_idx", 128'(bus.key_index), 128'(rev_tbl[j-1].idx_after));
                chk("rev_reg", sched, rev_tbl[j-1].key_after);
            end
            chk("rev_cs", 128'(bus.control_signal), 128'(rev_tbl[j].cs));
            chk("rev_rn", 128'(bus.round_number), 128'(rev_tbl[j].rn));
            chk("rev_rkv", 128'(bus.round_key_valid), 128'd1);
        end
        @(negedge clk);
        bus.round_advance = 1'b0;
        #1;
        chk("rev_final_idx", 128'(bus.key_index), 128'd0);
        chk("rev_final_reg", sched, rk[0]);
        chk("rev_final_rkv", 128'(bus.round_key_valid), 128'd1);

        // Advance at index 0 triggers in-place re-expansion
        @(negedge clk);
        bus.round_advance = 1'b1;
        #1;
        chk("reexp_rkv_drop", 128'(bus.round_key_valid), 128'd0);
        chk("reexp_cs_hold", 128'(bus.control_signal), 128'd0);
        lowcnt = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.round_advance = 1'b0;
            #1;
            if (bus.round_key_valid) break;
            lowcnt++;
        end
        chk("reexp_low_cycles", 128'(lowcnt), 128'd11);
        chk("reexp_idx", 128'(bus.key_index), 128'd10);
        chk("reexp_reg", sched, rk[10]);

        // New key and advance together: load wins
        load_key(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0, 1'b0, 4'd10,
                 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Inputs held high during expansion are ignored
        load_key(rk[0], 1'b0, 1'b1, 1'b1, 4'd10, rk[10]);

        // Asynchronous reset in the middle of expansion
        @(negedge clk);
        bus.key_valid = 1'b1;
        load_key_in   = rk[0];
        @(negedge clk);
        bus.key_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", 128'(bus.control_signal), 128'd0);
        chk("midrst_rn", 128'(bus.round_number), 128'd0);
        chk("midrst_key_ready", 128'(bus.key_ready), 128'd1);
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        chk("midrst_rkv", 128'(bus.round_key_valid), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b1;
        #1;
        chk("postrst_key_ready", 128'(bus.key_ready), 128'd1);
        @(negedge clk);
        bus.key_valid = 1'b0;
        #1;
        chk("postrst_load_cs", 128'(bus.control_signal), 128'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
